// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// fetch_entry_t is the FIFO payload: an instruction word plus the PC it was fetched from.
package fetch_queue_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_W     = 32;
  localparam int PC_STEP_DEF = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction memory request/response, redirect input and decode handshake.
// master = fetch unit, slave = memory/decode/branch environment.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order DEPTH-entry FIFO of fetch entries; head is read from the storage registers (zero when empty).
// Push on full and pop on empty are ignored; flush clears both pointers and beats push/pop.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  output fetch_entry_t           head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  logic         do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues one word request per cycle while FIFO credit allows, queues responses,
// 2 cycles request-to-instr_valid; redirect flushes queue and in-flight fetch. FETCH_STATS_EN adds counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = PC_STEP_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_queue_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]   stat_fetched,
  output logic [31:0]   stat_flushed,
  output logic [31:0]   stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    push_dat, head_dat;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            epoch_q, epoch_d, tag_q, tag_d, inflight_q, inflight_d;
  logic [AW+1:0]   occupancy;
  logic            issue, push, pop;

  // Credit counts the in-flight word so a response always has a free slot.
  assign occupancy = {1'b0, fifo_count} + {{(AW+1){1'b0}}, inflight_q};
  assign issue     = reset_n && !bus.redirect_valid && (occupancy < (AW+2)'(DEPTH));
  assign push      = bus.imem_rvalid && inflight_q && (tag_q == epoch_q)
                     && !bus.redirect_valid && !fifo_full;
  assign pop       = !fifo_empty && bus.instr_ready;
  assign push_dat  = '{instr: bus.imem_rdata, pc: req_pc_q};

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = head_dat.instr;
  assign bus.instr_pc    = head_dat.pc;

  always_comb begin
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    req_pc_d   = req_pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      epoch_d = ~epoch_q;
    end else if (issue) begin
      pc_d     = pc_q + XLEN'(PC_STEP);
      req_pc_d = pc_q;
      tag_d    = epoch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      epoch_q    <= 1'b0;
      tag_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      epoch_q    <= epoch_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (bus.redirect_valid),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d, stall_q, stall_d;
  logic [31:0] flush_inc;

  // Any response not pushed is stale; a redirect also discards every queued entry.
  always_comb begin
    flush_inc = (bus.imem_rvalid && !push) ? 32'd1 : 32'd0;
    if (bus.redirect_valid) flush_inc = flush_inc + 32'(fifo_count);
    fetched_d = sat_add32(fetched_q, {31'd0, push});
    flushed_d = sat_add32(flushed_q, flush_inc);
    stall_d   = sat_add32(stall_q, {31'd0, !fifo_empty && !bus.instr_ready});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
      stall_q   <= stall_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
  assign stat_stall   = stall_q;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of decode and the sign-extend unit.
- Owns the 64-bit PC and issues word requests to instruction memory.
- Buffers returned 32-bit instructions in a small in-order FIFO and presents them, with their PC, to decode over a valid/ready handshake.
- Handles branch redirects by flushing queued and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 64'h0, PC loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- imem_req  output  1  fetch request valid this cycle
- imem_addr  output  64  byte address of the request
- imem_rvalid  input  1  response valid; arrives exactly 1 cycle after its request
- imem_rdata  input  32  returned instruction word
- redirect_valid  input  1  branch/exception redirect
- redirect_pc  input  64  redirect target
- instr_valid  output  1  FIFO head valid
- instr_ready  input  1  decode accepts head
- instr  output  32  head instruction (feeds sign-extend/decode)
- instr_pc  output  64  PC of head instruction

Behaviour:
- Reset:
  - While reset_n=0 at a clk edge: pc=RESET_PC, FIFO empty, count=0, inflight=0, epoch=0.
  - Outputs after reset: imem_req=0 for that cycle, instr_valid=0, instr=0, instr_pc=0.
- Issue rule:
  - imem_req=1 when count + inflight < DEPTH and redirect_valid=0.
  - imem_addr=pc. On issue, pc += PC_STEP, with 64-bit wrap-around.
- Tracking:
  - inflight is 0 or 1, given the single-cycle memory latency.
  - Each request is tagged with the current epoch bit.
- Response:
  - When imem_rvalid=1 and the tag matches epoch, push {imem_rdata, request pc} into the FIFO.
  - On a tag mismatch, drop the response.
- Dequeue:
  - Pop when instr_valid & instr_ready.
  - instr and instr_pc are registered FIFO head outputs, stable while instr_valid=1 and instr_ready=0.
- Simultaneous push and pop: count unchanged, both take effect. A push into a full FIFO cannot occur because of the credit rule.
- Redirect (highest priority):
  - On the same edge: FIFO cleared, count=0, epoch toggles, pc=redirect_pc, no request issued that cycle.
  - Any response returning next cycle is dropped via the epoch mismatch.
  - A pop in the redirect cycle is discarded with the flush.
  - Next cycle: request at redirect_pc.
- Back-to-back redirects: the last one wins; every intervening response is dropped.
- Reset mid-operation: same as power-up reset; a response arriving in the cycle after reset is dropped (inflight=0).
- Throughput:
  - One instruction per cycle sustained when instr_ready=1.
  - Latency from first request to instr_valid is 2 cycles (memory + FIFO register).
- Alignment: pc[1:0] are carried but not checked; redirect_pc is written as-is.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, adds these outputs, all reset to 0, saturating at all-ones:
  - stat_fetched (32-bit): increments on each accepted push.
  - stat_flushed (32-bit): increments by the number of entries discarded on a redirect, plus 1 per dropped stale response.
  - stat_stall (32-bit): increments each cycle instr_valid=1 and instr_ready=0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - XLEN=64 and INSTR_W=32.
  - PC_STEP default.
  - fetch_entry_t = {instr[31:0], pc[63:0]}.
- One natural sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO.
  - Ports: push, pop, flush, full, empty, count.
  - Circular pointers with wrap bit.
- Top level owns the PC, epoch, credit and redirect logic.

Test Plan:
- Reset, then reset_n=1 with instr_ready=1 and the memory returning addr+0x1000 as data: imem_addr sequence 0,4,8,…; first instr_valid 2 cycles after first request; instr_pc 0 with instr 0x1000, then 4/0x1004.
- instr_ready=0 for 10 cycles: exactly DEPTH=4 requests issued, then imem_req=0. Release ready: 4 entries drain in order, fetch resumes at pc 0x10.
- Redirect to 0x400 while FIFO holds 3 entries and a request is in flight: instr_valid=0 next cycle, stale response dropped, next request address 0x400, first instr_pc 0x400.
- Redirect on two consecutive cycles (0x100 then 0x200): no entry from 0x100 is ever presented; first instr_pc is 0x200.
- Simultaneous push and pop at count=2 over 8 cycles: count stays 2, order preserved. With FETCH_STATS_EN, stat_fetched matches the push total.
- PC wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC: next addresses …FFFC then 0x0; reset_n=0 mid-stream: next request is RESET_PC and no stale entry appears.
